// File: rtl/gfx_pkg.sv
// Shared constants for the graphics register bank: address map, reset values,
// screen limits and the commit FSM encoding.
package gfx_pkg;

  localparam logic [3:0]  CS_GFX     = 4'b0100;
  localparam logic [18:0] LAST_PIXEL = 19'h4AFFF;
  localparam logic [15:0] X_MAX      = 16'd639;
  localparam logic [15:0] Y_MAX      = 16'd479;

  localparam int NUM_REGS = 10;

  localparam logic [3:0] ADDR_P1X    = 4'd0;
  localparam logic [3:0] ADDR_P1Y    = 4'd1;
  localparam logic [3:0] ADDR_P2X    = 4'd2;
  localparam logic [3:0] ADDR_P2Y    = 4'd3;
  localparam logic [3:0] ADDR_BX     = 4'd4;
  localparam logic [3:0] ADDR_BY     = 4'd5;
  localparam logic [3:0] ADDR_BZ     = 4'd6;
  localparam logic [3:0] ADDR_S1     = 4'd7;
  localparam logic [3:0] ADDR_S2     = 4'd8;
  localparam logic [3:0] ADDR_STATE  = 4'd9;
  localparam logic [3:0] ADDR_COMMIT = 4'd10;

  localparam logic [15:0] RST_P1X   = 16'd100;
  localparam logic [15:0] RST_P1Y   = 16'd200;
  localparam logic [15:0] RST_P2X   = 16'd350;
  localparam logic [15:0] RST_P2Y   = 16'd250;
  localparam logic [15:0] RST_BX    = 16'd320;
  localparam logic [15:0] RST_BY    = 16'd240;
  localparam logic [15:0] RST_BZ    = 16'd0;
  localparam logic [15:0] RST_S1    = 16'd0;
  localparam logic [15:0] RST_S2    = 16'd0;
  localparam logic [15:0] RST_STATE = 16'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } gfx_state_t;

  function automatic logic [15:0] reset_value(input int idx);
    case (idx)
      0:       return RST_P1X;
      1:       return RST_P1Y;
      2:       return RST_P2X;
      3:       return RST_P2Y;
      4:       return RST_BX;
      5:       return RST_BY;
      6:       return RST_BZ;
      7:       return RST_S1;
      8:       return RST_S2;
      default: return RST_STATE;
    endcase
  endfunction

endpackage

// File: rtl/gfx_coord_clamp.sv
// Unsigned saturating clamp of a coordinate against an upper limit.
module gfx_coord_clamp (
  input  logic [15:0] i_value,
  input  logic [15:0] i_limit,
  output logic [15:0] o_value
);

  assign o_value = (i_value > i_limit) ? i_limit : i_value;

endmodule

// File: rtl/gfx_reg_bank.sv
// CPU-written shadow registers that are copied to the live outputs atomically
// at the end of a frame, so the renderers never see a half-updated scene.
module gfx_reg_bank
  import gfx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  chipselect,
  input  logic [3:0]  data_address,
  input  logic [15:0] databus,
  input  logic        VGA_ready,
  input  logic [18:0] pixel_address,
  output logic [15:0] paddle_1_x,
  output logic [15:0] paddle_1_y,
  output logic [15:0] paddle_2_x,
  output logic [15:0] paddle_2_y,
  output logic [15:0] ball_x,
  output logic [15:0] ball_y,
  output logic [15:0] ball_z,
  output logic [15:0] player_1_score,
  output logic [15:0] player_2_score,
  output logic [15:0] game_state,
  output logic        commit_pending,
  output logic [15:0] frame_count,
  output logic        addr_err
);

  gfx_state_t  r_state;
  logic        r_commit_pending;
  logic [15:0] r_frame_count;
  logic        r_addr_err;

  logic        w_wr;
  logic        w_frame_end;
  logic        w_commit_wr;
  logic        w_commit;
  logic [15:0] w_x_clamped;
  logic [15:0] w_y_clamped;
  logic [15:0] w_wdata;

  assign w_wr        = (chipselect == CS_GFX);
  assign w_frame_end = VGA_ready && (pixel_address == LAST_PIXEL);
  assign w_commit_wr = w_wr && (data_address == ADDR_COMMIT);
  assign w_commit    = (r_state == ARMED) && w_frame_end;

  gfx_coord_clamp u_clamp_x (
    .i_value (databus),
    .i_limit (X_MAX),
    .o_value (w_x_clamped)
  );

  gfx_coord_clamp u_clamp_y (
    .i_value (databus),
    .i_limit (Y_MAX),
    .o_value (w_y_clamped)
  );

  always_comb begin
    w_wdata = databus;
    case (data_address)
      ADDR_P1X, ADDR_P2X, ADDR_BX: w_wdata = w_x_clamped;
      ADDR_P1Y, ADDR_P2Y, ADDR_BY: w_wdata = w_y_clamped;
      default:                     w_wdata = databus;
    endcase
  end

  // Commit reads the shadow value from before this cycle's write, so a write
  // coinciding with a commit only shows up at the next commit.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [15:0] r_shadow;
    logic [15:0] r_live;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_shadow <= reset_value(gi);
        r_live   <= reset_value(gi);
      end else begin
        if (w_commit)
          r_live <= r_shadow;
        if (w_wr && (data_address == 4'(gi)))
          r_shadow <= w_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_commit_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_commit_wr) begin
            r_state          <= ARMED;
            r_commit_pending <= 1'b1;
          end
        end
        ARMED: begin
          if (w_frame_end) begin
            r_state          <= IDLE;
            r_commit_pending <= 1'b0;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_commit_pending <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= 16'd0;
      r_addr_err    <= 1'b0;
    end else begin
      if (w_frame_end)
        r_frame_count <= r_frame_count + 16'd1;
      if (w_wr && (data_address > ADDR_COMMIT))
        r_addr_err <= 1'b1;
    end
  end

  assign paddle_1_x     = g_reg[0].r_live;
  assign paddle_1_y     = g_reg[1].r_live;
  assign paddle_2_x     = g_reg[2].r_live;
  assign paddle_2_y     = g_reg[3].r_live;
  assign ball_x         = g_reg[4].r_live;
  assign ball_y         = g_reg[5].r_live;
  assign ball_z         = g_reg[6].r_live;
  assign player_1_score = g_reg[7].r_live;
  assign player_2_score = g_reg[8].r_live;
  assign game_state     = g_reg[9].r_live;
  assign commit_pending = r_commit_pending;
  assign frame_count    = r_frame_count;
  assign addr_err       = r_addr_err;

endmodule

// File: doc/gfx_reg_bank.md
Name: gfx_reg_bank

Overview:
- CPU-facing register bank directly upstream of the graphics ASIC core. Captures CPU writes (chipselect/data_address/databus) into shadow registers.
- Commits all shadows atomically to the live outputs only at a frame boundary, so paddle, ball, score and state values stay constant across a rendered frame (no tearing).
- Live outputs drive the paddle, ball and frame/score renderers.

Parameters:
- CS_GFX, 4'b0100, chipselect value that selects this bank.
- LAST_PIXEL, 19'h4AFFF, pixel address of the final pixel of a frame (640x480-1).
- X_MAX, 16'd639, clamp ceiling for x-coordinate registers.
- Y_MAX, 16'd479, clamp ceiling for y-coordinate registers.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- chipselect  in  4  CPU chip select; write strobe when equal to CS_GFX
- data_address  in  4  register index
- databus  in  16  write data
- VGA_ready  in  1  pixel-pipeline advance strobe from the graphics core
- pixel_address  in  19  current pixel address from the graphics core
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  out  16 each  live paddle positions
- ball_x, ball_y, ball_z  out  16 each  live ball position
- player_1_score, player_2_score  out  16 each  live scores
- game_state  out  16  live game state
- commit_pending  out  1  commit armed, waiting for frame end
- frame_count  out  16  frames completed
- addr_err  out  1  sticky: write to an unmapped address

Behaviour:
- Write: wr = (chipselect == CS_GFX). Single-cycle; no back-pressure.
- Address map: 0 p1x, 1 p1y, 2 p2x, 3 p2y, 4 bx, 5 by, 6 bz, 7 s1, 8 s2, 9 state, 10 COMMIT (data ignored), 11-15 unmapped.
  - Unmapped write: no register change; sets addr_err. addr_err clears only on reset.
- Clamp on shadow write:
  - Addresses 0,2,4 store min(databus, X_MAX).
  - Addresses 1,3,5 store min(databus, Y_MAX).
  - Unsigned compare. Others stored verbatim.
- frame_end = VGA_ready && (pixel_address == LAST_PIXEL), evaluated combinationally each cycle.
- FSM:
  - IDLE: write to addr 10 -> ARMED. Shadow writes allowed.
  - ARMED: commit_pending=1. Shadow writes still allowed.
    - On frame_end: all 10 live registers <= shadow values (registered, visible next cycle); -> IDLE.
    - Another write to addr 10 while ARMED: no effect (stays ARMED).
- Simultaneous events:
  - Shadow write and commit in the same cycle: commit copies the pre-write shadow; the write lands in shadow only and appears at the next commit.
  - COMMIT write in IDLE coinciding with frame_end: arms only; commit happens at the following frame_end.
- frame_count increments on every frame_end regardless of state; wraps 16'hFFFF -> 0.
- Reset (shadow and live set identically; any cycle, including mid-ARMED):
  - p1x 100, p1y 200, p2x 350, p2y 250, bx 320, by 240, bz 0, s1 0, s2 0, state 0.
  - FSM IDLE, commit_pending 0, frame_count 0, addr_err 0.
- Latency: live outputs change exactly 1 cycle after the frame_end cycle; never at any other time (except reset).

Decomposition:
- Shared package gfx_pkg: register address constants (ADDR_P1X … ADDR_STATE, ADDR_COMMIT), reset-value constants, screen constants (X_MAX, Y_MAX, LAST_PIXEL), FSM state encoding (IDLE, ARMED).
- One sub-module: gfx_coord_clamp (combinational min against a limit), instantiated for the x and y paths.
- Shadow/live arrays and FSM stay in gfx_reg_bank.

Test Plan:
- Reset then idle 2 frames -> outputs hold reset values (p1x=100, p2y=250); frame_count=2; commit_pending=0.
- Write addr0=150, addr10, then frame_end -> p1x stays 100 until 1 cycle after frame_end, then 150; commit_pending 1->0.
- Write addr4=700 and addr5=500, commit, frame_end -> ball_x=639, ball_y=479.
- In ARMED, write addr7=5 in the same cycle as frame_end -> player_1_score unchanged (0) after commit. Second commit + frame_end -> 5.
- Write addr13=0xFFFF -> addr_err=1, no output change after commit; stays 1 until rst.
- Assert rst while ARMED with pending shadow p1x=300 -> next frame_end leaves p1x=100; commit_pending=0; frame_count restarts at 0; force frame_count to 0xFFFF, one frame_end -> 0.
